// File: rtl/corevx_tlb_pkg.sv
// Shared constants for the corevx TLB: physical page width, accesstag bit
// positions and the attribute word reported when translation is bypassed.
package corevx_tlb_pkg;

   localparam int PHYS_W = 22;
   localparam int VPN_W  = 20;

   // accesstag bit positions: {D,A,G,U,X,W,R,V}
   localparam int AT_V = 0;
   localparam int AT_R = 1;
   localparam int AT_W = 2;
   localparam int AT_X = 3;
   localparam int AT_U = 4;
   localparam int AT_G = 5;
   localparam int AT_A = 6;
   localparam int AT_D = 7;

   // Bypass attributes: everything permitted and dirty/accessed, not global.
   localparam logic [7:0] BYPASS_TAG = 8'hDF;

endpackage

// File: rtl/corevx_tlb_assoc_way.sv
// One TLB way: per-set valid/tag/asid/attribute/PPN storage, the lookup
// comparator for the request stage and the fill-side match/valid probes.
module corevx_tlb_assoc_way #(
   parameter int ENTRIES_W = 4,
   parameter int ASID_W    = 9,
   parameter int PHYS_W    = corevx_tlb_pkg::PHYS_W
) (
   input  logic                clk,
   input  logic                rst,
   // lookup side (request stage)
   input  logic [ENTRIES_W-1:0] set_r_i,
   input  logic [19-ENTRIES_W:0] tag_r_i,
   input  logic [ASID_W-1:0]   asid_r_i,
   output logic                hit_o,
   output logic [7:0]          atag_o,
   output logic [PHYS_W-1:0]   phys_o,
   // fill / maintenance side
   input  logic [ENTRIES_W-1:0] set_w_i,
   input  logic [19-ENTRIES_W:0] tag_w_i,
   input  logic [ASID_W-1:0]   asid_w_i,
   output logic                match_w_o,
   output logic                valid_w_o,
   input  logic                we_i,
   input  logic [7:0]          wtag_i,
   input  logic [PHYS_W-1:0]   wphys_i,
   input  logic                inv_all_i,
   input  logic                inv_va_i
);
   import corevx_tlb_pkg::*;

   localparam int SETS  = 1 << ENTRIES_W;
   localparam int TAG_W = VPN_W - ENTRIES_W;

   logic [SETS-1:0]   valid_q;
   logic [TAG_W-1:0]  tag_q  [SETS];
   logic [ASID_W-1:0] asid_q [SETS];
   logic [7:1]        atag_q [SETS];
   logic [PHYS_W-1:0] phys_q [SETS];

   // Valid bits: reset/flush-all clears everything, single-page flush drops
   // the tag match at the addressed set, a fill loads V from the new tag.
   always_ff @(posedge clk) begin
      if (rst || inv_all_i)
         valid_q <= '0;
      else if (inv_va_i) begin
         if (valid_q[set_w_i] && tag_q[set_w_i] == tag_w_i)
            valid_q[set_w_i] <= 1'b0;
      end else if (we_i)
         valid_q[set_w_i] <= wtag_i[AT_V];
   end

   // Entry payload: only meaningful while valid, so no reset needed.
   always_ff @(posedge clk) begin
      if (we_i) begin
         tag_q[set_w_i]  <= tag_w_i;
         asid_q[set_w_i] <= asid_w_i;
         atag_q[set_w_i] <= wtag_i[7:1];
         phys_q[set_w_i] <= wphys_i;
      end
   end

   // Lookup compare and readout; global pages ignore the ASID.
   always_comb begin
      hit_o  = valid_q[set_r_i] && tag_q[set_r_i] == tag_r_i &&
               (atag_q[set_r_i][AT_G] || asid_q[set_r_i] == asid_r_i);
      atag_o = hit_o ? {atag_q[set_r_i], 1'b1} : 8'h00;
      phys_o = hit_o ? phys_q[set_r_i] : '0;
   end

   // Fill-side probes used by the top to pick the victim way.
   always_comb begin
      valid_w_o = valid_q[set_w_i];
      match_w_o = valid_q[set_w_i] && tag_q[set_w_i] == tag_w_i &&
                  (atag_q[set_w_i][AT_G] || asid_q[set_w_i] == asid_w_i);
   end

endmodule

// File: rtl/corevx_tlb_assoc.sv
// Set-associative TLB top: request stage, per-set round-robin victim
// pointers, fill-way selection, maintenance priority and result mux.
module corevx_tlb_assoc #(
   parameter int ENTRIES_W = 4,
   parameter int WAYS      = 2,
   parameter int ASID_W    = 9,
   parameter int PHYS_W    = corevx_tlb_pkg::PHYS_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              enable,
   input  logic [19:0]       virtual_address,
   input  logic [ASID_W-1:0] asid,
   input  logic              resolve,
   output logic              done,
   output logic              miss,
   output logic [7:0]        accesstag_r,
   output logic [PHYS_W-1:0] phys_r,
   input  logic              write,
   input  logic [19:0]       virtual_address_w,
   input  logic [ASID_W-1:0] asid_w,
   input  logic [7:0]        accesstag_w,
   input  logic [PHYS_W-1:0] phys_w,
   input  logic              invalidate,
   input  logic              invalidate_va
);
   import corevx_tlb_pkg::*;

   localparam int SETS  = 1 << ENTRIES_W;
   // A single way still gets a 1-bit pointer that never leaves 0.
   localparam int PTR_W = (WAYS > 1) ? $clog2(WAYS) : 1;

   logic              req_vld_q;
   logic              en_q;
   logic [19:0]       va_q;
   logic [ASID_W-1:0] asid_q;

   logic [PTR_W-1:0]  ptr_q [SETS];
   logic [PTR_W-1:0]  ptr_d;
   logic [PTR_W-1:0]  fill_way;
   logic              evict;

   logic              do_inv_va;
   logic              do_write;

   logic [WAYS-1:0]              hit;
   logic [WAYS-1:0]              match_w;
   logic [WAYS-1:0]              valid_w;
   logic [WAYS-1:0]              way_we;
   logic [WAYS-1:0][7:0]         rd_atag;
   logic [WAYS-1:0][PHYS_W-1:0]  rd_phys;

   logic [ENTRIES_W-1:0] set_w;
   assign set_w     = virtual_address_w[ENTRIES_W-1:0];
   assign do_inv_va = invalidate_va && !invalidate;
   assign do_write  = write && !invalidate && !invalidate_va;

   for (genvar g = 0; g < WAYS; g++) begin : g_way
      assign way_we[g] = do_write && fill_way == PTR_W'(g);

      corevx_tlb_assoc_way #(
         .ENTRIES_W(ENTRIES_W),
         .ASID_W   (ASID_W),
         .PHYS_W   (PHYS_W)
      ) u_way (
         .clk      (clk),
         .rst      (rst),
         .set_r_i  (va_q[ENTRIES_W-1:0]),
         .tag_r_i  (va_q[19:ENTRIES_W]),
         .asid_r_i (asid_q),
         .hit_o    (hit[g]),
         .atag_o   (rd_atag[g]),
         .phys_o   (rd_phys[g]),
         .set_w_i  (set_w),
         .tag_w_i  (virtual_address_w[19:ENTRIES_W]),
         .asid_w_i (asid_w),
         .match_w_o(match_w[g]),
         .valid_w_o(valid_w[g]),
         .we_i     (way_we[g]),
         .wtag_i   (accesstag_w),
         .wphys_i  (phys_w),
         .inv_all_i(invalidate),
         .inv_va_i (do_inv_va)
      );
   end

   // Request stage: capture the lookup; reset drops an outstanding one.
   always_ff @(posedge clk) begin
      if (rst) begin
         req_vld_q <= 1'b0;
         en_q      <= 1'b0;
         va_q      <= '0;
         asid_q    <= '0;
      end else begin
         req_vld_q <= resolve;
         if (resolve) begin
            en_q   <= enable;
            va_q   <= virtual_address;
            asid_q <= asid;
         end
      end
   end

   // Fill way: reuse a matching entry, else lowest invalid, else the victim.
   always_comb begin
      logic found;
      fill_way = '0;
      found    = 1'b0;
      for (int i = 0; i < WAYS; i++)
         if (!found && match_w[i]) begin
            fill_way = PTR_W'(i);
            found    = 1'b1;
         end
      for (int i = 0; i < WAYS; i++)
         if (!found && !valid_w[i]) begin
            fill_way = PTR_W'(i);
            found    = 1'b1;
         end
      evict = !found;
      if (!found)
         fill_way = ptr_q[set_w];
      ptr_d = (ptr_q[set_w] == PTR_W'(WAYS - 1)) ? '0 : ptr_q[set_w] + 1'b1;
   end

   // Victim pointers move only when an eviction actually happens.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int s = 0; s < SETS; s++)
            ptr_q[s] <= '0;
      end else if (do_write && evict)
         ptr_q[set_w] <= ptr_d;
   end

   // Result mux: bypass, lowest-index hit, or miss; all zero when idle.
   always_comb begin
      done        = req_vld_q;
      miss        = 1'b0;
      accesstag_r = 8'h00;
      phys_r      = '0;
      if (req_vld_q) begin
         if (!en_q) begin
            accesstag_r = BYPASS_TAG;
            phys_r      = PHYS_W'(va_q);
         end else if (|hit) begin
            for (int i = WAYS - 1; i >= 0; i--)
               if (hit[i]) begin
                  accesstag_r = rd_atag[i];
                  phys_r      = rd_phys[i];
               end
         end else
            miss = 1'b1;
      end
   end

endmodule

// File: tb/tb_corevx_tlb_assoc.sv
// Bench for corevx_tlb_assoc: directed fills/flushes/lookups with literal
// expectations, plus an entry-list model compared every cycle.
module tb_corevx_tlb_assoc;

   localparam int WAYS   = 2;
   localparam int SETS   = 16;
   localparam int ASID_W = 9;
   localparam int PHYS_W = 22;

   logic              clk = 1'b0;
   logic              rst;
   logic              enable;
   logic [19:0]       virtual_address;
   logic [ASID_W-1:0] asid;
   logic              resolve;
   logic              done;
   logic              miss;
   logic [7:0]        accesstag_r;
   logic [PHYS_W-1:0] phys_r;
   logic              write;
   logic [19:0]       virtual_address_w;
   logic [ASID_W-1:0] asid_w;
   logic [7:0]        accesstag_w;
   logic [PHYS_W-1:0] phys_w;
   logic              invalidate;
   logic              invalidate_va;

   int checks = 0;
   int errors = 0;

   corevx_tlb_assoc #(.ENTRIES_W(4), .WAYS(WAYS), .ASID_W(ASID_W), .PHYS_W(PHYS_W)) dut (
      .clk(clk), .rst(rst), .enable(enable), .virtual_address(virtual_address),
      .asid(asid), .resolve(resolve), .done(done), .miss(miss),
      .accesstag_r(accesstag_r), .phys_r(phys_r), .write(write),
      .virtual_address_w(virtual_address_w), .asid_w(asid_w),
      .accesstag_w(accesstag_w), .phys_w(phys_w), .invalidate(invalidate),
      .invalidate_va(invalidate_va)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Each way/set slot holds a full VPN; a lookup scans the slots of the set.
   bit          m_v    [WAYS][SETS];
   bit [19:0]   m_vpn  [WAYS][SETS];
   bit [8:0]    m_asid [WAYS][SETS];
   bit [7:0]    m_at   [WAYS][SETS];
   bit [21:0]   m_phys [WAYS][SETS];
   int          m_ptr  [SETS];
   bit          rq_v, rq_en, started;
   bit [19:0]   rq_va;
   bit [8:0]    rq_asid;

   function automatic int m_find(input bit [19:0] vpn, input bit [8:0] a);
      int s = int'(vpn % SETS);
      for (int w = 0; w < WAYS; w++)
         if (m_v[w][s] && m_vpn[w][s] == vpn && (m_at[w][s][5] || m_asid[w][s] == a))
            return w;
      return -1;
   endfunction

   always @(posedge clk) begin
      started = 1'b1;
      if (rst) begin
         for (int w = 0; w < WAYS; w++)
            for (int s = 0; s < SETS; s++) m_v[w][s] = 1'b0;
         for (int s = 0; s < SETS; s++) m_ptr[s] = 0;
         rq_v = 1'b0;
      end else begin
         int s, way;
         rq_v = resolve;
         if (resolve) begin
            rq_en = enable; rq_va = virtual_address; rq_asid = asid;
         end
         s = int'(virtual_address_w % SETS);
         if (invalidate) begin
            for (int w = 0; w < WAYS; w++)
               for (int k = 0; k < SETS; k++) m_v[w][k] = 1'b0;
         end else if (invalidate_va) begin
            for (int w = 0; w < WAYS; w++)
               if (m_vpn[w][s] == virtual_address_w) m_v[w][s] = 1'b0;
         end else if (write) begin
            way = m_find(virtual_address_w, asid_w);
            if (way < 0)
               for (int w = WAYS - 1; w >= 0; w--)
                  if (!m_v[w][s]) way = w;
            if (way < 0) begin
               way = m_ptr[s];
               m_ptr[s] = (m_ptr[s] + 1) % WAYS;
            end
            m_v[way][s]    = accesstag_w[0];
            m_vpn[way][s]  = virtual_address_w;
            m_asid[way][s] = asid_w;
            m_at[way][s]   = accesstag_w;
            m_phys[way][s] = phys_w;
         end
      end
   end

   // Every-cycle comparison against the model.
   always @(negedge clk) begin
      if (started) begin
         bit       e_done, e_miss;
         bit [7:0] e_at;
         bit [21:0] e_ph;
         int       w;
         e_done = rq_v; e_miss = 0; e_at = 0; e_ph = 0;
         if (rq_v) begin
            if (!rq_en) begin
               e_at = 8'hDF; e_ph = {2'b00, rq_va};
            end else begin
               w = m_find(rq_va, rq_asid);
               if (w < 0) e_miss = 1;
               else begin
                  e_at = {m_at[w][rq_va % SETS][7:1], 1'b1};
                  e_ph = m_phys[w][rq_va % SETS];
               end
            end
         end
         check("model_done", 32'(done), 32'(e_done));
         check("model_miss", 32'(miss), 32'(e_miss));
         check("model_tag",  32'(accesstag_r), 32'(e_at));
         check("model_phys", 32'(phys_r), 32'(e_ph));
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic lookup(input logic en, input logic [19:0] va, input logic [8:0] a);
      enable = en; virtual_address = va; asid = a; resolve = 1'b1;
      @(negedge clk);
      resolve = 1'b0;
   endtask

   task automatic fill(input logic [19:0] va, input logic [8:0] a, input logic [7:0] at,
                       input logic [21:0] ph);
      virtual_address_w = va; asid_w = a; accesstag_w = at; phys_w = ph; write = 1'b1;
      @(negedge clk);
      write = 1'b0;
   endtask

   task automatic expect_out(input string name, input logic d, input logic m,
                             input logic [7:0] at, input logic [21:0] ph);
      check({name, "_done"}, 32'(done), 32'(d));
      check({name, "_miss"}, 32'(miss), 32'(m));
      check({name, "_tag"},  32'(accesstag_r), 32'(at));
      check({name, "_phys"}, 32'(phys_r), 32'(ph));
   endtask

   initial begin
      rst = 1'b1; enable = 0; virtual_address = 0; asid = 0; resolve = 0;
      write = 0; virtual_address_w = 0; asid_w = 0; accesstag_w = 0; phys_w = 0;
      invalidate = 0; invalidate_va = 0;
      repeat (3) @(negedge clk);
      expect_out("reset", 0, 0, 8'h00, 22'h0);
      rst = 1'b0;

      lookup(1, 20'h12345, 9'd0);
      expect_out("cold_miss", 1, 1, 8'h00, 22'h0);
      lookup(0, 20'h00ABC, 9'd0);
      expect_out("bypass", 1, 0, 8'hDF, 22'h000ABC);
      @(negedge clk);
      expect_out("idle_zero", 0, 0, 8'h00, 22'h0);

      // Round-robin eviction in set 0.
      fill(20'h00010, 9'd3, 8'h0F, 22'h00100);
      fill(20'h00020, 9'd3, 8'h0F, 22'h00200);
      fill(20'h00030, 9'd3, 8'h0F, 22'h00300);
      lookup(1, 20'h00010, 9'd3);
      expect_out("evicted", 1, 1, 8'h00, 22'h0);
      lookup(1, 20'h00020, 9'd3);
      expect_out("rr_keep", 1, 0, 8'h0F, 22'h00200);
      lookup(1, 20'h00030, 9'd3);
      expect_out("rr_new", 1, 0, 8'h0F, 22'h00300);

      // Global page, then rewrite non-global into the same way.
      fill(20'h00040, 9'd1, 8'h2F, 22'h00400);
      lookup(1, 20'h00040, 9'd7);
      expect_out("global_hit", 1, 0, 8'h2F, 22'h00400);
      fill(20'h00040, 9'd1, 8'h0F, 22'h00401);
      lookup(1, 20'h00040, 9'd7);
      expect_out("nonglobal_miss", 1, 1, 8'h00, 22'h0);
      lookup(1, 20'h00040, 9'd1);
      expect_out("rewrite_hit", 1, 0, 8'h0F, 22'h00401);
      lookup(1, 20'h00030, 9'd3);
      expect_out("no_duplicate", 1, 0, 8'h0F, 22'h00300);

      // Single-page flush then flush-all.
      fill(20'h00050, 9'd2, 8'h03, 22'h00500);
      fill(20'h00061, 9'd2, 8'h03, 22'h00610);
      virtual_address_w = 20'h00050; invalidate_va = 1'b1;
      @(negedge clk);
      invalidate_va = 1'b0;
      lookup(1, 20'h00050, 9'd2);
      expect_out("inv_va_gone", 1, 1, 8'h00, 22'h0);
      lookup(1, 20'h00061, 9'd2);
      expect_out("inv_va_other", 1, 0, 8'h03, 22'h00610);
      invalidate = 1'b1;
      @(negedge clk);
      invalidate = 1'b0;
      lookup(1, 20'h00061, 9'd2);
      expect_out("inv_all_a", 1, 1, 8'h00, 22'h0);
      lookup(1, 20'h00040, 9'd1);
      expect_out("inv_all_b", 1, 1, 8'h00, 22'h0);

      // Same-cycle resolve + write sees the new entry.
      enable = 1; virtual_address = 20'h00070; asid = 9'd2; resolve = 1'b1;
      virtual_address_w = 20'h00070; asid_w = 9'd2; accesstag_w = 8'h07;
      phys_w = 22'h00700; write = 1'b1;
      @(negedge clk);
      resolve = 1'b0; write = 1'b0;
      expect_out("rw_same_cycle", 1, 0, 8'h07, 22'h00700);

      // Same-cycle resolve + invalidate misses.
      virtual_address = 20'h00070; resolve = 1'b1; invalidate = 1'b1;
      @(negedge clk);
      resolve = 1'b0; invalidate = 1'b0;
      expect_out("ri_same_cycle", 1, 1, 8'h00, 22'h0);

      // invalidate wins over a concurrent write.
      virtual_address_w = 20'h00080; asid_w = 9'd2; accesstag_w = 8'h07;
      phys_w = 22'h00800; write = 1'b1; invalidate = 1'b1;
      @(negedge clk);
      write = 1'b0; invalidate = 1'b0;
      lookup(1, 20'h00080, 9'd2);
      expect_out("write_dropped", 1, 1, 8'h00, 22'h0);

      // Back-to-back resolves.
      fill(20'h00093, 9'd4, 8'h17, 22'h00930);
      enable = 1; virtual_address = 20'h00093; asid = 9'd4; resolve = 1'b1;
      @(negedge clk);
      expect_out("b2b_first", 1, 0, 8'h17, 22'h00930);
      virtual_address = 20'h00094;
      @(negedge clk);
      resolve = 1'b0;
      expect_out("b2b_second", 1, 1, 8'h00, 22'h0);

      // Reset cancels a lookup issued in the same cycle.
      virtual_address = 20'h00093; resolve = 1'b1; rst = 1'b1;
      @(negedge clk);
      resolve = 1'b0; rst = 1'b0;
      expect_out("rst_cancel", 0, 0, 8'h00, 22'h0);
      lookup(1, 20'h00093, 9'd4);
      expect_out("rst_cleared", 1, 1, 8'h00, 22'h0);

      repeat (2) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
